// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce slice: counter sizing for the stability filter.
package sync_debounce_pkg;

  // Bits needed to count 0..filter, never less than one.
  function automatic int unsigned cnt_width(input int unsigned filter);
    return (filter == 0) ? 1 : $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_chan.sv
// One channel: synchroniser, stability filter and registered dout/rise/fall.
module sync_debounce_chan
  import sync_debounce_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter int unsigned FILTER    = 0,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW      = cnt_width(FILTER);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER);

  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

  sync_debounce_sync #(
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .s     (s)
  );

  // s must have differed from dout for FILTER+1 consecutive cycles.
  always_comb begin
    accept = (s != dout) && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      dout <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
      if ((s == dout) || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        dout <= s;
      end
    end
  end

endmodule

// File: rtl/sync_debounce_sync.sv
// Per-bit synchroniser chain, isolated in its own hierarchy so CDC constraints can target it.
module sync_debounce_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign s = chain[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser with stability filter and edge strobes; wiring only.
module sync_debounce #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter int unsigned      FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_debounce_chan #(
      .STAGES    (STAGES),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL[i])
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (din[i]),
      .dout  (dout[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: vector table plus hand-written multi-cycle sequences.
module tb_sync_debounce;

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'hF;
  logic [3:0] dout, rise, fall;
  logic       din2 = 1'b0;
  logic       dout2, rise2, fall2;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sync_debounce #(
    .WIDTH     (4),
    .STAGES    (2),
    .FILTER    (3),
    .RESET_VAL (4'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall)
  );

  sync_debounce #(
    .WIDTH     (1),
    .STAGES    (3),
    .FILTER    (0),
    .RESET_VAL (1'b0)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .din   (din2),
    .dout  (dout2),
    .rise  (rise2),
    .fall  (fall2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_main(input string name, input logic [3:0] d, input logic [3:0] r,
                             input logic [3:0] f);
    check({name, ".dout"}, dout, d);
    check({name, ".rise"}, rise, r);
    check({name, ".fall"}, fall, f);
  endtask

  task automatic expect_inst2(input string name, input logic d, input logic r, input logic f);
    check({name, ".dout"}, {3'b0, dout2}, {3'b0, d});
    check({name, ".rise"}, {3'b0, rise2}, {3'b0, r});
    check({name, ".fall"}, {3'b0, fall2}, {3'b0, f});
  endtask

  task automatic add(input logic r, input logic [3:0] d, input logic [3:0] dv,
                     input logic [3:0] rv, input logic [3:0] fv, input int reps);
    vec_t v;
    v.rst = r; v.din = d; v.dout = dv; v.rise = rv; v.fall = fv;
    for (int k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with din high, release, full 6-edge qualification, then clean fall and rise on bit 0.
    add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4);
    add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
    add(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    add(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 2);
    add(1'b0, 4'hE, 4'hF, 4'h0, 4'h0, 5);
    add(1'b0, 4'hE, 4'hE, 4'h0, 4'h1, 1);
    add(1'b0, 4'hE, 4'hE, 4'h0, 4'h0, 2);
    add(1'b0, 4'hF, 4'hE, 4'h0, 4'h0, 5);
    add(1'b0, 4'hF, 4'hF, 4'h1, 4'h0, 1);
    add(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      din   = vecs[i].din;
      tick();
      expect_main($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise, vecs[i].fall);
    end

    // Return to an all-zero baseline.
    reset = 1'b1; din = 4'h0;
    tick(); tick();
    expect_main("rst_base", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    tick();
    expect_main("rst_base_rel", 4'h0, 4'h0, 4'h0);

    // Three-cycle glitch on bit 1 must be rejected.
    din = 4'h2;
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) din = 4'h0;
      tick();
      expect_main($sformatf("glitch3_t%0d", t), 4'h0, 4'h0, 4'h0);
    end

    // Four-cycle pulse on bit 1 qualifies; fall follows four cycles after rise.
    din = 4'h2;
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) din = 4'h0;
      tick();
      expect_main($sformatf("glitch4_t%0d", t),
                  (t >= 6 && t <= 9) ? 4'h2 : 4'h0,
                  (t == 6) ? 4'h2 : 4'h0,
                  (t == 10) ? 4'h2 : 4'h0);
    end

    // Pre-qualify bit 3 high.
    din = 4'h8;
    for (int t = 1; t <= 8; t++) begin
      tick();
      expect_main($sformatf("pre3_t%0d", t), (t >= 6) ? 4'h8 : 4'h0,
                  (t == 6) ? 4'h8 : 4'h0, 4'h0);
    end

    // Simultaneous rise on bit 2 and fall on bit 3.
    din = 4'h4;
    for (int t = 1; t <= 7; t++) begin
      tick();
      expect_main($sformatf("simul_t%0d", t), (t >= 6) ? 4'h4 : 4'h8,
                  (t == 6) ? 4'h4 : 4'h0, (t == 6) ? 4'h8 : 4'h0);
    end

    // Bring bit 0 to cnt=2, then reset mid-filter.
    din = 4'h5;
    for (int t = 1; t <= 4; t++) begin
      tick();
      expect_main($sformatf("midf_t%0d", t), 4'h4, 4'h0, 4'h0);
    end
    reset = 1'b1; din = 4'h1;
    for (int t = 1; t <= 2; t++) begin
      tick();
      expect_main($sformatf("midf_rst%0d", t), 4'h0, 4'h0, 4'h0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      expect_main($sformatf("midf_rel_t%0d", t), (t >= 6) ? 4'h1 : 4'h0,
                  (t == 6) ? 4'h1 : 4'h0, 4'h0);
    end

    // STAGES=3, FILTER=0 instance: 4-edge latency both ways.
    din2 = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      expect_inst2($sformatf("f0_rise_t%0d", t), t >= 4, t == 4, 1'b0);
    end
    din2 = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      expect_inst2($sformatf("f0_fall_t%0d", t), t < 4, 1'b0, t == 4);
    end

    // Single-cycle pulse passes straight through with no filter.
    din2 = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      if (t == 2) din2 = 1'b0;
      tick();
      expect_inst2($sformatf("f0_pulse_t%0d", t), t == 4, t == 4, t == 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
